// File: rtl/seq_pattern_gen_if.sv
// Control and status bundle for the serial pattern transmitter.
//   start      burst request, only looked at while the generator is idle
//   repeat_n   number of pattern repetitions, captured together with start
//   overlap    1 = later repetitions reuse the tail of the previous one
//   abort      drops an active burst back to idle without a done pulse
//   x          serial data bit, MSB of the pattern first
//   valid      x carries a pattern bit this cycle
//   frame_end  last bit of a repetition
//   busy       generator is not idle
//   done       one-cycle pulse after a burst completes normally
// master: the controller or bench that drives the request side.
// slave : the generator itself.
interface seq_pattern_gen_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] repeat_n;
  logic             overlap;
  logic             abort;
  logic             x;
  logic             valid;
  logic             frame_end;
  logic             busy;
  logic             done;

  modport master (
    output start, repeat_n, overlap, abort,
    input  x, valid, frame_end, busy, done
  );

  modport slave (
    input  start, repeat_n, overlap, abort,
    output x, valid, frame_end, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter. Sends PATTERN MSB-first on bus.x, one bit per
// clock, repeat_n times per burst. In overlapping mode every repetition after
// the first starts at bit OVL, so the last OVL bits of one repetition double as
// the head of the next.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_pattern_gen_if.slave (start/repeat_n/overlap/abort in,
//          x/valid/frame_end/busy/done out); all outputs are registered.
// Build option:
//   SEQGEN_GAP_EN  when defined, non-overlapping bursts insert GAP_LEN idle
//                  cycles between repetitions (never after the last one).
module seq_pattern_gen #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int             OVL     = 2,
  parameter int             CNT_W   = 4,
  parameter int             GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_pattern_gen_if.slave  bus
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] OVL_IDX  = IDX_W'(OVL);

  // Reject parameter sets the datapath cannot represent.
  if (OVL < 0 || OVL >= PAT_W || GAP_LEN < 1 || PAT_W < 2 || PAT_W > 16) begin : g_bad_param
    $error("seq_pattern_gen: illegal PAT_W/OVL/GAP_LEN combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FIN
`ifdef SEQGEN_GAP_EN
    , GAP
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] bit_idx, idx_nxt;
  logic [CNT_W-1:0] rep_cnt, rep_nxt;
  logic             ovl_mode, ovl_nxt;
  logic             x_r, valid_r, frame_end_r, busy_r, done_r;
  logic             x_nxt, valid_nxt, frame_end_nxt, busy_nxt, done_nxt;

`ifdef SEQGEN_GAP_EN
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = bit_idx;
    rep_nxt   = rep_cnt;
    ovl_nxt   = ovl_mode;
`ifdef SEQGEN_GAP_EN
    gap_nxt   = gap_cnt;
`endif
    if (bus.abort && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.repeat_n != '0) begin
              state_nxt = SEND;
              idx_nxt   = '0;
              rep_nxt   = bus.repeat_n;
              ovl_nxt   = bus.overlap;
            end else begin
              state_nxt = FIN;
            end
          end
        end
        SEND: begin
          if (bit_idx == LAST_IDX) begin
            // Counter counts down to 1, so repeat_n = all-ones never wraps.
            rep_nxt = rep_cnt - 1'b1;
            if (rep_cnt == CNT_W'(1)) begin
              state_nxt = FIN;
            end else if (ovl_mode) begin
              idx_nxt = OVL_IDX;
            end else begin
              idx_nxt = '0;
`ifdef SEQGEN_GAP_EN
              state_nxt = GAP;
              gap_nxt   = '0;
`endif
            end
          end else begin
            idx_nxt = bit_idx + 1'b1;
          end
        end
`ifdef SEQGEN_GAP_EN
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_LEN - 1)) begin
            state_nxt = SEND;
          end else begin
            gap_nxt = gap_cnt + 1'b1;
          end
        end
`endif
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // alongside it, giving first-bit latency of one cycle after start.
    x_nxt         = 1'b0;
    valid_nxt     = 1'b0;
    frame_end_nxt = 1'b0;
    if (state_nxt == SEND) begin
      x_nxt         = PATTERN[LAST_IDX - idx_nxt];
      valid_nxt     = 1'b1;
      frame_end_nxt = (idx_nxt == LAST_IDX);
    end
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_idx     <= '0;
      rep_cnt     <= '0;
      ovl_mode    <= 1'b0;
      x_r         <= 1'b0;
      valid_r     <= 1'b0;
      frame_end_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_idx     <= idx_nxt;
      rep_cnt     <= rep_nxt;
      ovl_mode    <= ovl_nxt;
      x_r         <= x_nxt;
      valid_r     <= valid_nxt;
      frame_end_r <= frame_end_nxt;
      busy_r      <= busy_nxt;
      done_r      <= done_nxt;
    end
  end

`ifdef SEQGEN_GAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_cnt <= '0;
    else        gap_cnt <= gap_nxt;
  end
`endif

  assign bus.x         = x_r;
  assign bus.valid     = valid_r;
  assign bus.frame_end = frame_end_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule
